// File: rtl/udp_payload_buffer.sv
// udp_payload_buffer: two-bank rx/tx payload store with commit/discard and drop accounting.
// Optional greeting-frame preload is enabled by defining UDP_PAYLOAD_PRELOAD_EN.
`default_nettype none

module udp_payload_buffer #(
  parameter int ADDR_W = 9,
  parameter int LEN_W  = 16,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic              init_done,
  input  logic              wr_valid,
  input  logic [31:0]       wr_data,
  input  logic              wr_last,
  input  logic              wr_err,
  input  logic [LEN_W-1:0]  wr_len,
  output logic              rx_ready,
  output logic              tx_avail,
  output logic              tx_is_default,
  output logic [LEN_W-1:0]  tx_len,
  input  logic              tx_start,
  input  logic              tx_done,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              ovf
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]      mem [0:2*DEPTH-1];
  logic [1:0]       bank_full;
  logic [LEN_W-1:0] bank_len [2];
  logic             rx_bank;
  logic             tx_bank;
  logic [ADDR_W:0]  rx_addr;
  logic             rx_active;
  logic             rx_bad;
  logic             rx_drop;
  logic             tx_busy;
  logic             default_valid;
`ifdef UDP_PAYLOAD_PRELOAD_EN
  logic [2:0]       init_cnt;

  function automatic logic [31:0] greeting(input logic [2:0] idx);
    case (idx)
      3'd0:    greeting = "HELL";
      3'd1:    greeting = "O WO";
      3'd2:    greeting = "RLD\n";
      3'd3:    greeting = "Xiao";
      3'd4:    greeting = "meig";
      3'd5:    greeting = "e_fp";
      default: greeting = "ga \n";
    endcase
  endfunction
`endif

  logic            rx_fire, frame_drop, at_limit, wr_word, ovf_now, commit;
  logic            retire, tx_accept, tx_release;
  logic [1:0]      bank_full_nxt;
  logic            mem_we;
  logic [ADDR_W:0] mem_waddr;
  logic [31:0]     mem_wdata;

  assign rx_fire    = init_done & wr_valid;
  // Drop decision is latched at the first word so a bank freed mid-frame cannot receive a partial frame.
  assign frame_drop = rx_active ? rx_drop : bank_full[rx_bank];
  assign at_limit   = rx_addr[ADDR_W];
  assign wr_word    = rx_fire & ~frame_drop & ~at_limit;
  assign ovf_now    = rx_fire & ~frame_drop & at_limit;
  assign commit     = rx_fire & wr_last & ~frame_drop & ~wr_err & ~rx_bad & ~at_limit;
  assign retire     = default_valid & bank_full[1] & ~tx_busy;
  assign tx_accept  = init_done & tx_start & tx_avail & ~tx_busy & ~retire;
  assign tx_release = tx_done & tx_busy;

  assign tx_avail      = bank_full[tx_bank] & init_done;
  assign tx_len        = bank_len[tx_bank];
  assign tx_is_default = default_valid & ~tx_bank;
  assign rx_ready      = ~bank_full[rx_bank] & init_done;

  always_comb begin
    bank_full_nxt = bank_full;
    if (tx_release && !tx_is_default) bank_full_nxt[tx_bank] = 1'b0;
    if (retire)                       bank_full_nxt[0]       = 1'b0;
    if (commit)                       bank_full_nxt[rx_bank] = 1'b1;
  end

  always_comb begin
    mem_we    = wr_word;
    mem_waddr = {rx_bank, rx_addr[ADDR_W-1:0]};
    mem_wdata = wr_data;
`ifdef UDP_PAYLOAD_PRELOAD_EN
    if (!init_done) begin
      mem_we    = 1'b1;
      mem_waddr = {1'b0, ADDR_W'(init_cnt)};
      mem_wdata = greeting(init_cnt);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data <= '0;
    else       rd_data <= mem[{tx_bank, rd_addr}];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      init_done     <= 1'b0;
      bank_full     <= '0;
      bank_len[0]   <= '0;
      bank_len[1]   <= '0;
      rx_bank       <= 1'b0;
      tx_bank       <= 1'b0;
      rx_addr       <= '0;
      rx_active     <= 1'b0;
      rx_bad        <= 1'b0;
      rx_drop       <= 1'b0;
      tx_busy       <= 1'b0;
      default_valid <= 1'b0;
      drop_cnt      <= '0;
      ovf           <= 1'b0;
`ifdef UDP_PAYLOAD_PRELOAD_EN
      init_cnt      <= '0;
`endif
    end else if (!init_done) begin
`ifdef UDP_PAYLOAD_PRELOAD_EN
      init_cnt <= init_cnt + 3'd1;
      if (init_cnt == 3'd6) begin
        init_done     <= 1'b1;
        bank_full     <= 2'b01;
        bank_len[0]   <= LEN_W'(28);
        default_valid <= 1'b1;
        tx_bank       <= 1'b0;
        rx_bank       <= 1'b1;
      end
`else
      init_done <= 1'b1;
`endif
    end else begin
      bank_full <= bank_full_nxt;
      ovf       <= ovf_now & ~rx_bad;

      if (commit) begin
        bank_len[rx_bank] <= wr_len;
        rx_bank           <= ~rx_bank;
      end

      if (retire) begin
        tx_bank       <= 1'b1;
        default_valid <= 1'b0;
      end else if (tx_release && !tx_is_default) begin
        tx_bank <= ~tx_bank;
      end

      if (tx_release)     tx_busy <= 1'b0;
      else if (tx_accept) tx_busy <= 1'b1;

      if (rx_fire) begin
        if (wr_last) begin
          rx_addr   <= '0;
          rx_active <= 1'b0;
          rx_bad    <= 1'b0;
          rx_drop   <= 1'b0;
          if (!commit && drop_cnt != {DROP_W{1'b1}}) drop_cnt <= drop_cnt + DROP_W'(1);
        end else begin
          rx_active <= 1'b1;
          rx_drop   <= frame_drop;
          if (wr_word) rx_addr <= rx_addr + (ADDR_W+1)'(1);
          if (ovf_now) rx_bad  <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_udp_payload_buffer.sv
// Directed self-checking bench for udp_payload_buffer (small banks: ADDR_W=3).
`default_nettype none

module tb_udp_payload_buffer;

  localparam int ADDR_W = 3;
  localparam int LEN_W  = 16;
  localparam int DROP_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              init_done;
  logic              wr_valid = 1'b0;
  logic [31:0]       wr_data = '0;
  logic              wr_last = 1'b0;
  logic              wr_err = 1'b0;
  logic [LEN_W-1:0]  wr_len = '0;
  logic              rx_ready, tx_avail, tx_is_default;
  logic [LEN_W-1:0]  tx_len;
  logic              tx_start = 1'b0;
  logic              tx_done = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [31:0]       rd_data;
  logic [DROP_W-1:0] drop_cnt;
  logic              ovf;

  int checks = 0;
  int failures = 0;
  int ovf_seen = 0;
  int ovf_base;

  udp_payload_buffer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .DROP_W(DROP_W)) dut (
    .clk(clk), .reset(reset), .init_done(init_done),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last), .wr_err(wr_err), .wr_len(wr_len),
    .rx_ready(rx_ready), .tx_avail(tx_avail), .tx_is_default(tx_is_default), .tx_len(tx_len),
    .tx_start(tx_start), .tx_done(tx_done), .rd_addr(rd_addr), .rd_data(rd_data),
    .drop_cnt(drop_cnt), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (ovf === 1'b1) ovf_seen++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int n, input logic [31:0] base, input int len, input logic err);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = base + 32'(i);
      wr_last  = (i == n - 1);
      wr_err   = err;
      wr_len   = LEN_W'(len);
      tick();
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    wr_err   = 1'b0;
  endtask

  task automatic pulse_start();
    tx_start = 1'b1; tick(); tx_start = 1'b0;
  endtask

  task automatic pulse_done();
    tx_done = 1'b1; tick(); tx_done = 1'b0;
  endtask

  task automatic read_check(input string tag, input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      rd_addr = ADDR_W'(i);
      tick();
      check_eq(tag, rd_data, base + 32'(i));
    end
  endtask

`ifdef UDP_PAYLOAD_PRELOAD_EN
  logic [31:0] greet [7];
`endif

  initial begin
    tick();
    tick();
    check_eq("rst_init_done", {31'b0, init_done}, 32'd0);
    check_eq("rst_tx_avail", {31'b0, tx_avail}, 32'd0);
    check_eq("rst_rx_ready", {31'b0, rx_ready}, 32'd0);
    check_eq("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check_eq("rst_ovf", {31'b0, ovf}, 32'd0);
    check_eq("rst_rd_data", rd_data, 32'd0);
    check_eq("rst_tx_len", 32'(tx_len), 32'd0);
    reset = 1'b0;

`ifdef UDP_PAYLOAD_PRELOAD_EN
    greet[0] = 32'h48454C4C; greet[1] = 32'h4F20574F; greet[2] = 32'h524C440A;
    greet[3] = 32'h5869616F; greet[4] = 32'h6D656967; greet[5] = 32'h655F6670;
    greet[6] = 32'h6761200A;
    for (int i = 0; i < 6; i++) tick();
    check_eq("init_done_c6", {31'b0, init_done}, 32'd0);
    tick();
    check_eq("init_done_c7", {31'b0, init_done}, 32'd1);
    check_eq("def_avail", {31'b0, tx_avail}, 32'd1);
    check_eq("def_len", 32'(tx_len), 32'd28);
    check_eq("def_is_default", {31'b0, tx_is_default}, 32'd1);
    for (int i = 0; i < 7; i++) begin
      rd_addr = ADDR_W'(i);
      tick();
      check_eq("greet_word", rd_data, greet[i]);
    end
    for (int r = 0; r < 3; r++) begin
      pulse_start();
      check_eq("rep_len_busy", 32'(tx_len), 32'd28);
      pulse_done();
      check_eq("rep_avail", {31'b0, tx_avail}, 32'd1);
      check_eq("rep_len", 32'(tx_len), 32'd28);
    end
    send_frame(4, 32'hB0000000, 13, 1'b0);
    tick();
    check_eq("retire_len", 32'(tx_len), 32'd13);
    check_eq("retire_not_default", {31'b0, tx_is_default}, 32'd0);
    read_check("retire_rd", 4, 32'hB0000000);
    pulse_start();
    pulse_done();
    check_eq("retire_done_avail", {31'b0, tx_avail}, 32'd0);
`else
    tick();
    check_eq("init_done_c1", {31'b0, init_done}, 32'd1);
    check_eq("empty_avail", {31'b0, tx_avail}, 32'd0);
    check_eq("empty_rx_ready", {31'b0, rx_ready}, 32'd1);
    check_eq("empty_default", {31'b0, tx_is_default}, 32'd0);
    pulse_start();
    check_eq("start_no_avail", {31'b0, tx_avail}, 32'd0);

    // Frame A into bank 0 becomes the tx frame right after its last word.
    send_frame(5, 32'hA0000000, 19, 1'b0);
    check_eq("a_avail", {31'b0, tx_avail}, 32'd1);
    check_eq("a_len", 32'(tx_len), 32'd19);
    check_eq("a_not_default", {31'b0, tx_is_default}, 32'd0);
    check_eq("a_rx_ready", {31'b0, rx_ready}, 32'd1);
    read_check("a_rd", 5, 32'hA0000000);

    send_frame(3, 32'hB0000000, 10, 1'b0);
    check_eq("b_tx_len", 32'(tx_len), 32'd19);
    check_eq("b_rx_ready", {31'b0, rx_ready}, 32'd0);

    send_frame(2, 32'hC0000000, 7, 1'b0);
    check_eq("full_drop_cnt", 32'(drop_cnt), 32'd1);
    check_eq("full_rx_ready", {31'b0, rx_ready}, 32'd0);
    check_eq("full_tx_len", 32'(tx_len), 32'd19);
    read_check("full_no_write", 1, 32'hA0000000);

    pulse_start();
    pulse_done();
    check_eq("swap_len", 32'(tx_len), 32'd10);
    check_eq("swap_avail", {31'b0, tx_avail}, 32'd1);
    check_eq("swap_rx_ready", {31'b0, rx_ready}, 32'd1);
    read_check("b_rd", 3, 32'hB0000000);

    send_frame(4, 32'hE0000000, 15, 1'b1);
    check_eq("err_drop_cnt", 32'(drop_cnt), 32'd2);
    check_eq("err_rx_ready", {31'b0, rx_ready}, 32'd1);
    check_eq("err_tx_len", 32'(tx_len), 32'd10);

    ovf_base = ovf_seen;
    send_frame(9, 32'hF0000000, 36, 1'b0);
    tick();
    check_eq("ovf_pulses", 32'(ovf_seen - ovf_base), 32'd1);
    check_eq("ovf_drop_cnt", 32'(drop_cnt), 32'd3);
    check_eq("ovf_rx_ready", {31'b0, rx_ready}, 32'd1);
    check_eq("ovf_tx_len", 32'(tx_len), 32'd10);

    send_frame(1, 32'hD0000000, 3, 1'b0);
    check_eq("single_rx_ready", {31'b0, rx_ready}, 32'd0);
    check_eq("single_tx_len", 32'(tx_len), 32'd10);
    check_eq("single_drop_cnt", 32'(drop_cnt), 32'd3);

    pulse_done();
    check_eq("idle_done_avail", {31'b0, tx_avail}, 32'd1);
    check_eq("idle_done_len", 32'(tx_len), 32'd10);

    pulse_start();
    pulse_done();
    check_eq("d_len", 32'(tx_len), 32'd3);
    read_check("d_rd", 1, 32'hD0000000);
    pulse_start();
    pulse_done();
    check_eq("drained_avail", {31'b0, tx_avail}, 32'd0);
    check_eq("drained_rx_ready", {31'b0, rx_ready}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
